// File: rtl/fpu_arb_pkg.sv
// Shared types and latency constants for the fadd request scheduler.
package fpu_arb_pkg;

  localparam int unsigned FADD_LAT  = 2;
  localparam int unsigned ISSUE_LAT = 1;
  localparam int unsigned RSP_LAT   = ISSUE_LAT + FADD_LAT;
  localparam int unsigned MAX_NREQ  = 8;
  localparam int unsigned ID_W      = $clog2(MAX_NREQ);

  typedef logic [31:0] word_t;

  // The tag id is sized for the largest supported requester count, so one
  // type serves every NREQ.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or after ptr.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] gidx
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (en) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        idx = (int'(ptr) + i) % int'(NREQ);
        if (!found && req[idx[PTR_W-1:0]]) begin
          found                = 1'b1;
          gnt[idx[PTR_W-1:0]]  = 1'b1;
          gidx                 = idx[PTR_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Round-robin front end sharing one two-stage fadd pipeline among NREQ
// requesters, with an owner-tag pipeline that routes each result back.
module fadd_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  word_t [NREQ-1:0]      req_x1,
  input  word_t [NREQ-1:0]      req_x2,
  input  logic [NREQ-1:0]       req_sub,
  input  logic                  hold,
  output word_t                 fadd_x1,
  output word_t                 fadd_x2,
  input  word_t                 fadd_y,
  output logic [NREQ-1:0]       rsp_valid,
  output word_t                 rsp_y,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_issued
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]         ptr_q;
  logic [PTR_W-1:0]         ptr_nxt;
  logic [PTR_W-1:0]         gidx;
  logic                     accept;
  word_t                    x1_q;
  word_t                    x2_q;
  tag_t [RSP_LAT-1:0]       tag_q;
  logic [CNT_W-1:0]         ops_q;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
    .req  (req_valid),
    .ptr  (ptr_q),
    .en   (~hold),
    .gnt  (req_ready),
    .gidx (gidx)
  );

  always_comb begin
    accept  = |(req_valid & req_ready);
    ptr_nxt = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
  end

  // Issue stage: pointer, operand capture (subtract folds into x2 sign), counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      x1_q  <= '0;
      x2_q  <= '0;
      ops_q <= '0;
    end else if (accept) begin
      ptr_q <= ptr_nxt;
      x1_q  <= req_x1[gidx];
      x2_q  <= {req_x2[gidx][31] ^ req_sub[gidx], req_x2[gidx][30:0]};
      ops_q <= ops_q + CNT_W'(1);
    end
  end

  // Owner tags advance in lockstep with the adder; no stall path exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= '{valid: accept, id: ID_W'(gidx)};
      for (int i = 1; i < int'(RSP_LAT); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    busy      = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      rsp_valid[i] = tag_q[RSP_LAT-1].valid && (tag_q[RSP_LAT-1].id == ID_W'(i));
    end
    for (int i = 0; i < int'(RSP_LAT); i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

  assign fadd_x1    = x1_q;
  assign fadd_x2    = x2_q;
  assign rsp_y      = fadd_y;
  assign ops_issued = ops_q;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter with a two-stage stand-in adder.
module tb_fadd_arbiter;
  import fpu_arb_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  word_t [NREQ-1:0]  req_x1;
  word_t [NREQ-1:0]  req_x2;
  logic [NREQ-1:0]   req_sub;
  logic              hold;
  word_t             fadd_x1;
  word_t             fadd_x2;
  word_t             fadd_y = '0;
  word_t             add_s1 = '0;
  logic [NREQ-1:0]   rsp_valid;
  word_t             rsp_y;
  logic              busy;
  logic [CNT_W-1:0]  ops_issued;

  int n_checks = 0;
  int n_fail   = 0;

  fadd_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x1     (req_x1),
    .req_x2     (req_x2),
    .req_sub    (req_sub),
    .hold       (hold),
    .fadd_x1    (fadd_x1),
    .fadd_x2    (fadd_x2),
    .fadd_y     (fadd_y),
    .rsp_valid  (rsp_valid),
    .rsp_y      (rsp_y),
    .busy       (busy),
    .ops_issued (ops_issued)
  );

  always #5 clk = ~clk;

  // Stand-in adder: exact results for the float cases used, integer sum otherwise.
  function automatic word_t fadd_ref(input word_t a, input word_t b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
    return a + b;
  endfunction

  always @(posedge clk) begin
    add_s1 <= fadd_ref(fadd_x1, fadd_x2);
    fadd_y <= add_s1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       hold;
    logic [3:0] ready;
    logic [3:0] rsp;
    logic       busy;
    logic [3:0] ops;
  } vec_t;

  vec_t tbl [25];

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;

    // Fairness run, then hold, then pointer / drop / counter-wrap corners.
    for (int r = 0; r < 12; r++) begin
      logic [3:0] one;
      one = 4'b0001;
      tbl[r] = '{4'hF, 1'b0, one << (r % 4),
                 (r >= 3) ? (one << ((r - 3) % 4)) : 4'h0,
                 (r != 0), 4'(r)};
    end
    tbl[12] = '{4'hF, 1'b1, 4'h0, 4'h2, 1'b1, 4'd12};
    tbl[13] = '{4'hF, 1'b1, 4'h0, 4'h4, 1'b1, 4'd12};
    tbl[14] = '{4'hF, 1'b1, 4'h0, 4'h8, 1'b1, 4'd12};
    tbl[15] = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 4'd12};
    tbl[16] = '{4'hA, 1'b0, 4'h2, 4'h0, 1'b0, 4'd12};
    tbl[17] = '{4'h1, 1'b0, 4'h1, 4'h0, 1'b1, 4'd13};
    tbl[18] = '{4'h9, 1'b0, 4'h8, 4'h0, 1'b1, 4'd14};
    tbl[19] = '{4'h0, 1'b0, 4'h0, 4'h2, 1'b1, 4'd15};
    tbl[20] = '{4'hD, 1'b0, 4'h1, 4'h1, 1'b1, 4'd15};
    tbl[21] = '{4'h0, 1'b0, 4'h0, 4'h8, 1'b1, 4'd0};
    tbl[22] = '{4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 4'd0};
    tbl[23] = '{4'h0, 1'b0, 4'h0, 4'h1, 1'b1, 4'd0};
    tbl[24] = '{4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'd0};

    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_sub   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_x1[i] = 32'h0100_0000 * (i + 1);
      req_x2[i] = 32'h10 * (i + 1);
    end

    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset fadd_x1", fadd_x1, 32'h0);
    chk("reset fadd_x2", fadd_x2, 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset ops_issued", 32'(ops_issued), 32'h0);
    tick();
    rst_n = 1'b1;

    for (int r = 0; r < 25; r++) begin
      req_valid = tbl[r].valid;
      hold      = tbl[r].hold;
      @(negedge clk);
      chk($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(tbl[r].ready));
      chk($sformatf("row%0d rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rsp));
      chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].busy));
      chk($sformatf("row%0d ops_issued", r), 32'(ops_issued), 32'(tbl[r].ops));
      if (tbl[r].rsp != 4'h0) begin
        id = onehot_idx(tbl[r].rsp);
        chk($sformatf("row%0d rsp_y", r), rsp_y, fadd_ref(req_x1[id], req_x2[id]));
      end
      tick();
    end
    hold = 1'b0;

    // Single add from requester 1 (ptr is 1 after the table).
    req_x1[1]  = 32'h3F80_0000;
    req_x2[1]  = 32'h4000_0000;
    req_valid  = 4'b0010;
    @(negedge clk);
    chk("add req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("add fadd_x1", fadd_x1, 32'h3F80_0000);
    chk("add fadd_x2", fadd_x2, 32'h4000_0000);
    chk("add rsp c+1", 32'(rsp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("add rsp c+2", 32'(rsp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("add rsp_valid", 32'(rsp_valid), 32'h2);
    chk("add rsp_y", rsp_y, 32'h4040_0000);
    tick();
    @(negedge clk);
    chk("add rsp c+4", 32'(rsp_valid), 32'h0);
    chk("add busy idle", 32'(busy), 32'h0);

    // Subtract from requester 0: sign of x2 flips on the way into the adder.
    req_x1[0]  = 32'h4040_0000;
    req_x2[0]  = 32'h3F80_0000;
    req_sub[0] = 1'b1;
    req_valid  = 4'b0001;
    @(negedge clk);
    chk("sub req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    req_sub   = '0;
    @(negedge clk);
    chk("sub fadd_x1", fadd_x1, 32'h4040_0000);
    chk("sub fadd_x2", fadd_x2, 32'hBF80_0000);
    tick();
    tick();
    @(negedge clk);
    chk("sub rsp_valid", 32'(rsp_valid), 32'h1);
    chk("sub rsp_y", rsp_y, 32'h4000_0000);
    tick();

    // Reset with two operations in flight: both must vanish.
    req_valid = 4'hF;
    @(negedge clk);
    chk("mid grant A", 32'(req_ready), 32'h2);
    tick();
    @(negedge clk);
    chk("mid grant B", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("mid rst busy", 32'(busy), 32'h0);
    chk("mid rst ops", 32'(ops_issued), 32'h0);
    chk("mid rst fadd_x1", fadd_x1, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("mid no rsp %0d", k), 32'(rsp_valid), 32'h0);
      chk($sformatf("mid busy %0d", k), 32'(busy), 32'h0);
      tick();
    end
    req_valid = 4'hF;
    @(negedge clk);
    chk("mid ptr cleared", 32'(req_ready), 32'h1);
    chk("mid ops cleared", 32'(ops_issued), 32'h0);
    tick();
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
